// File: rtl/inst_fetch_mem.sv
// Instruction memory with a LOAD phase (program streamed in word by word) and a
// RUN phase (one-cycle-latency fetch with a valid/ready instruction output).
module inst_fetch_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              loadValid,
  input  logic [DATA_W-1:0] loadData,
  input  logic              loadLast,
  output logic              loadReady,
  input  logic              loadStart,
  input  logic              fetchReq,
  input  logic [ADDR_W-1:0] fetchAddr,
  output logic              fetchReady,
  output logic              instValid,
  output logic [DATA_W-1:0] instruction,
  input  logic              instReady,
  output logic              misaligned,
  output logic              loaded,
  output logic [ADDR_W-2:0] wordCount
);

  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam int CNT_W = ADDR_W - 1;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_wordCount;
  logic              r_loaded;
  logic              r_instValid;
  logic              r_misaligned;
  logic [DATA_W-1:0] r_instruction;

  logic              w_loadBeat;
  logic              w_lastBeat;
  logic              w_fetchReady;
  logic              w_fetchAccept;
  logic [ADDR_W-3:0] w_fetchIdx;
  logic              w_inRange;

  assign w_loadBeat    = loadValid && (r_state == ST_LOAD);
  assign w_lastBeat    = loadLast || (r_wordCount == CNT_W'(DEPTH - 1));
  assign w_fetchReady  = (r_state == ST_RUN) && !loadStart && (!r_instValid || instReady);
  assign w_fetchAccept = fetchReq && w_fetchReady;
  assign w_fetchIdx    = fetchAddr[ADDR_W-1:2];
  // Words at or beyond the loaded count read as NOP, which also hides stale
  // contents left in the array across a reset or a reload.
  assign w_inRange     = {1'b0, w_fetchIdx} < r_wordCount;

  always_ff @(posedge clk) begin
    if (rst_n && w_loadBeat) begin
      r_mem[r_wordCount[ADDR_W-3:0]] <= loadData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_LOAD;
      r_wordCount   <= '0;
      r_loaded      <= 1'b0;
      r_instValid   <= 1'b0;
      r_instruction <= '0;
      r_misaligned  <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_loadBeat) begin
            r_wordCount <= r_wordCount + CNT_W'(1);
            if (w_lastBeat) begin
              r_state  <= ST_RUN;
              r_loaded <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // A reload waits until the held instruction has been consumed.
          if (loadStart && !r_instValid) begin
            r_state     <= ST_LOAD;
            r_wordCount <= '0;
            r_loaded    <= 1'b0;
          end
        end
        default: r_state <= ST_LOAD;
      endcase

      if (w_fetchAccept) begin
        r_instValid   <= 1'b1;
        r_instruction <= w_inRange ? r_mem[w_fetchIdx] : '0;
        r_misaligned  <= (fetchAddr[1:0] != 2'b00);
      end else if (r_instValid && instReady) begin
        r_instValid <= 1'b0;
      end
    end
  end

  assign loadReady   = (r_state == ST_LOAD);
  assign fetchReady  = w_fetchReady;
  assign instValid   = r_instValid;
  assign instruction = r_instruction;
  assign misaligned  = r_misaligned;
  assign loaded      = r_loaded;
  assign wordCount   = r_wordCount;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Self-checking bench for inst_fetch_mem: directed program load/fetch scenarios
// plus randomized fetch traffic checked against a word-array reference model.
module tb_inst_fetch_mem;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              loadValid = 1'b0;
  logic [DATA_W-1:0] loadData = '0;
  logic              loadLast = 1'b0;
  logic              loadReady;
  logic              loadStart = 1'b0;
  logic              fetchReq = 1'b0;
  logic [ADDR_W-1:0] fetchAddr = '0;
  logic              fetchReady;
  logic              instValid;
  logic [DATA_W-1:0] instruction;
  logic              instReady = 1'b1;
  logic              misaligned;
  logic              loaded;
  logic [ADDR_W-2:0] wordCount;

  int checks = 0;
  int fails  = 0;

  // Reference model: program words, number loaded, and the held output.
  logic [DATA_W-1:0] mMem [DEPTH];
  int                mCount = 0;
  logic              mValid = 1'b0;
  logic              mMis = 1'b0;
  logic [DATA_W-1:0] mInst = '0;

  logic [DATA_W-1:0] prog [3] = '{32'h20080005, 32'h2009000A, 32'h01095020};

  inst_fetch_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .loadValid(loadValid), .loadData(loadData), .loadLast(loadLast), .loadReady(loadReady),
    .loadStart(loadStart),
    .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchReady(fetchReady),
    .instValid(instValid), .instruction(instruction), .instReady(instReady),
    .misaligned(misaligned), .loaded(loaded), .wordCount(wordCount)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (loadReady !== 1'b1) begin fails++; $display("[TB] FAIL reset_loadReady: got %b expected 1", loadReady); end
    checks++; if (wordCount !== 7'd0) begin fails++; $display("[TB] FAIL reset_wordCount: got %0d expected 0", wordCount); end
    checks++; if (loaded !== 1'b0) begin fails++; $display("[TB] FAIL reset_loaded: got %b expected 0", loaded); end
    checks++; if (instValid !== 1'b0) begin fails++; $display("[TB] FAIL reset_instValid: got %b expected 0", instValid); end
    checks++; if (instruction !== 32'h0) begin fails++; $display("[TB] FAIL reset_instruction: got %h expected 0", instruction); end
    checks++; if (misaligned !== 1'b0) begin fails++; $display("[TB] FAIL reset_misaligned: got %b expected 0", misaligned); end
    checks++; if (fetchReady !== 1'b0) begin fails++; $display("[TB] FAIL reset_fetchReady: got %b expected 0", fetchReady); end
    tick();
    rst_n = 1'b1;
    mCount = 0;
    mValid = 1'b0;
  endtask

  task automatic test_load3;
    for (int i = 0; i < 3; i++) begin
      loadValid = 1'b1;
      loadData  = prog[i];
      loadLast  = (i == 2);
      checks++; if (loadReady !== 1'b1) begin fails++; $display("[TB] FAIL load3_ready%0d: got %b expected 1", i, loadReady); end
      tick();
      mMem[i] = prog[i];
      mCount++;
    end
    loadValid = 1'b0;
    loadLast  = 1'b0;
    checks++; if (wordCount !== 7'(mCount)) begin fails++; $display("[TB] FAIL load3_wordCount: got %0d expected %0d", wordCount, mCount); end
    checks++; if (loaded !== 1'b1) begin fails++; $display("[TB] FAIL load3_loaded: got %b expected 1", loaded); end
    checks++; if (loadReady !== 1'b0) begin fails++; $display("[TB] FAIL load3_loadReady: got %b expected 0", loadReady); end
  endtask

  task automatic test_back_to_back;
    instReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetchReq  = 1'b1;
      fetchAddr = 8'(i * 4);
      #1;
      checks++; if (fetchReady !== 1'b1) begin fails++; $display("[TB] FAIL b2b_fetchReady%0d: got %b expected 1", i, fetchReady); end
      tick();
      checks++; if (instValid !== 1'b1) begin fails++; $display("[TB] FAIL b2b_valid%0d: got %b expected 1", i, instValid); end
      checks++; if (instruction !== mMem[i]) begin fails++; $display("[TB] FAIL b2b_inst%0d: got %h expected %h", i, instruction, mMem[i]); end
      checks++; if (misaligned !== 1'b0) begin fails++; $display("[TB] FAIL b2b_mis%0d: got %b expected 0", i, misaligned); end
    end
    fetchReq = 1'b0;
    tick();
    checks++; if (instValid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_drain: got %b expected 0", instValid); end
  endtask

  task automatic test_misaligned;
    fetchReq  = 1'b1;
    fetchAddr = 8'h05;
    tick();
    checks++; if (instruction !== 32'h2009000A) begin fails++; $display("[TB] FAIL mis_inst: got %h expected 2009000a", instruction); end
    checks++; if (misaligned !== 1'b1) begin fails++; $display("[TB] FAIL mis_flag: got %b expected 1", misaligned); end
    fetchAddr = 8'h0C;
    tick();
    checks++; if (instruction !== 32'h0) begin fails++; $display("[TB] FAIL nop_inst: got %h expected 0", instruction); end
    checks++; if (instValid !== 1'b1) begin fails++; $display("[TB] FAIL nop_valid: got %b expected 1", instValid); end
    checks++; if (misaligned !== 1'b0) begin fails++; $display("[TB] FAIL nop_mis: got %b expected 0", misaligned); end
    fetchReq = 1'b0;
    tick();
  endtask

  task automatic test_stall;
    instReady = 1'b0;
    fetchReq  = 1'b1;
    fetchAddr = 8'h00;
    tick();
    fetchAddr = 8'h08;
    for (int k = 0; k < 3; k++) begin
      checks++; if (instValid !== 1'b1) begin fails++; $display("[TB] FAIL stall_valid%0d: got %b expected 1", k, instValid); end
      checks++; if (instruction !== 32'h20080005) begin fails++; $display("[TB] FAIL stall_inst%0d: got %h expected 20080005", k, instruction); end
      checks++; if (fetchReady !== 1'b0) begin fails++; $display("[TB] FAIL stall_fetchReady%0d: got %b expected 0", k, fetchReady); end
      tick();
    end
    fetchReq  = 1'b0;
    instReady = 1'b1;
    tick();
    checks++; if (instValid !== 1'b0) begin fails++; $display("[TB] FAIL stall_release: got %b expected 0", instValid); end
  endtask

  task automatic test_random_fetch(input int n);
    logic              req, rdy, expFr;
    logic [ADDR_W-1:0] addr;
    int                idx;
    mValid = 1'b0;
    for (int i = 0; i < n; i++) begin
      req  = ($urandom_range(0, 3) != 0);
      rdy  = $urandom_range(0, 1) == 1;
      addr = 8'($urandom_range(0, 255));
      fetchReq  = req;
      instReady = rdy;
      fetchAddr = addr;
      #1;
      expFr = !mValid || rdy;
      checks++; if (fetchReady !== expFr) begin fails++; $display("[TB] FAIL rnd_fetchReady%0d: got %b expected %b", i, fetchReady, expFr); end
      tick();
      if (req && expFr) begin
        idx    = int'(addr) / 4;
        mValid = 1'b1;
        mInst  = (idx < mCount) ? mMem[idx] : '0;
        mMis   = (addr % 4) != 0;
      end else if (mValid && rdy) begin
        mValid = 1'b0;
      end
      checks++; if (instValid !== mValid) begin fails++; $display("[TB] FAIL rnd_valid%0d: got %b expected %b", i, instValid, mValid); end
      if (mValid) begin
        checks++; if (instruction !== mInst) begin fails++; $display("[TB] FAIL rnd_inst%0d: got %h expected %h", i, instruction, mInst); end
        checks++; if (misaligned !== mMis) begin fails++; $display("[TB] FAIL rnd_mis%0d: got %b expected %b", i, misaligned, mMis); end
      end
    end
    fetchReq  = 1'b0;
    instReady = 1'b1;
    tick();
    mValid = 1'b0;
  endtask

  task automatic test_load_start;
    instReady = 1'b0;
    fetchReq  = 1'b1;
    fetchAddr = 8'h04;
    tick();
    fetchReq  = 1'b0;
    loadStart = 1'b1;
    tick();
    tick();
    checks++; if (loadReady !== 1'b0) begin fails++; $display("[TB] FAIL ls_pending_state: got %b expected 0", loadReady); end
    checks++; if (wordCount !== 7'(mCount)) begin fails++; $display("[TB] FAIL ls_pending_count: got %0d expected %0d", wordCount, mCount); end
    checks++; if (instValid !== 1'b1) begin fails++; $display("[TB] FAIL ls_pending_valid: got %b expected 1", instValid); end
    checks++; if (instruction !== mMem[1]) begin fails++; $display("[TB] FAIL ls_pending_inst: got %h expected %h", instruction, mMem[1]); end
    instReady = 1'b1;
    fetchReq  = 1'b1;
    fetchAddr = 8'h00;
    #1;
    checks++; if (fetchReady !== 1'b0) begin fails++; $display("[TB] FAIL ls_priority_ready: got %b expected 0", fetchReady); end
    tick();
    checks++; if (instValid !== 1'b0) begin fails++; $display("[TB] FAIL ls_drain_valid: got %b expected 0", instValid); end
    checks++; if (loadReady !== 1'b0) begin fails++; $display("[TB] FAIL ls_drain_state: got %b expected 0", loadReady); end
    tick();
    checks++; if (loadReady !== 1'b1) begin fails++; $display("[TB] FAIL ls_load_state: got %b expected 1", loadReady); end
    checks++; if (wordCount !== 7'd0) begin fails++; $display("[TB] FAIL ls_load_count: got %0d expected 0", wordCount); end
    checks++; if (loaded !== 1'b0) begin fails++; $display("[TB] FAIL ls_load_loaded: got %b expected 0", loaded); end
    checks++; if (instValid !== 1'b0) begin fails++; $display("[TB] FAIL ls_priority_valid: got %b expected 0", instValid); end
    loadStart = 1'b0;
    fetchReq  = 1'b0;
    tick();
    checks++; if (loadReady !== 1'b1) begin fails++; $display("[TB] FAIL ls_load_idle: got %b expected 1", loadReady); end
    mCount = 0;
  endtask

  task automatic test_full_load;
    for (int i = 0; i < DEPTH; i++) begin
      loadValid = 1'b1;
      loadLast  = 1'b0;
      loadData  = $urandom;
      mMem[i]   = loadData;
      checks++; if (loadReady !== 1'b1) begin fails++; $display("[TB] FAIL full_ready%0d: got %b expected 1", i, loadReady); end
      tick();
      mCount++;
      if (i == DEPTH - 2) begin
        checks++; if (loaded !== 1'b0) begin fails++; $display("[TB] FAIL full_early_loaded: got %b expected 0", loaded); end
      end
    end
    checks++; if (wordCount !== 7'd64) begin fails++; $display("[TB] FAIL full_count: got %0d expected 64", wordCount); end
    checks++; if (loaded !== 1'b1) begin fails++; $display("[TB] FAIL full_loaded: got %b expected 1", loaded); end
    checks++; if (loadReady !== 1'b0) begin fails++; $display("[TB] FAIL full_loadReady: got %b expected 0", loadReady); end
    for (int k = 0; k < 3; k++) begin
      loadData = ~mMem[k];
      tick();
    end
    loadValid = 1'b0;
    checks++; if (wordCount !== 7'd64) begin fails++; $display("[TB] FAIL full_overrun_count: got %0d expected 64", wordCount); end
  endtask

  task automatic test_reset_midload;
    logic [DATA_W-1:0] w;
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
    checks++; if (loadReady !== 1'b1) begin fails++; $display("[TB] FAIL rml_enter_load: got %b expected 1", loadReady); end
    for (int i = 0; i < 2; i++) begin
      loadValid = 1'b1;
      loadData  = $urandom;
      tick();
    end
    loadData = $urandom;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (loadReady !== 1'b1) begin fails++; $display("[TB] FAIL rml_loadReady: got %b expected 1", loadReady); end
    checks++; if (wordCount !== 7'd0) begin fails++; $display("[TB] FAIL rml_wordCount: got %0d expected 0", wordCount); end
    checks++; if (loaded !== 1'b0) begin fails++; $display("[TB] FAIL rml_loaded: got %b expected 0", loaded); end
    checks++; if (instValid !== 1'b0) begin fails++; $display("[TB] FAIL rml_instValid: got %b expected 0", instValid); end
    checks++; if (instruction !== 32'h0) begin fails++; $display("[TB] FAIL rml_instruction: got %h expected 0", instruction); end
    checks++; if (misaligned !== 1'b0) begin fails++; $display("[TB] FAIL rml_misaligned: got %b expected 0", misaligned); end
    loadValid = 1'b0;
    tick();
    rst_n  = 1'b1;
    mCount = 0;
    w = $urandom;
    loadValid = 1'b1;
    loadData  = w;
    loadLast  = 1'b1;
    tick();
    loadValid = 1'b0;
    loadLast  = 1'b0;
    mMem[0] = w;
    mCount  = 1;
    checks++; if (wordCount !== 7'd1) begin fails++; $display("[TB] FAIL rml_reload_count: got %0d expected 1", wordCount); end
    fetchReq  = 1'b1;
    fetchAddr = 8'h04;
    tick();
    checks++; if (instruction !== 32'h0) begin fails++; $display("[TB] FAIL rml_stale_nop: got %h expected 0", instruction); end
    fetchAddr = 8'h00;
    tick();
    checks++; if (instruction !== w) begin fails++; $display("[TB] FAIL rml_reload_inst: got %h expected %h", instruction, w); end
    fetchReq = 1'b0;
    tick();
  endtask

  initial begin
    $display("[TB] starting inst_fetch_mem bench");
    test_reset();
    test_load3();
    test_back_to_back();
    test_misaligned();
    test_stall();
    test_random_fetch(120);
    test_load_start();
    test_full_load();
    test_random_fetch(200);
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
